// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared definitions for the maze solver / path checker family:
//               maze geometry, direction encodings, checker error codes and
//               the checker state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

    // Maze geometry: DIM x DIM cells, row-major, cell index = row*DIM + col.
    localparam int DIM   = 17;
    localparam int CELLS = DIM * DIM;

    // Direction encodings carried on the solver's output stream.
    localparam logic [1:0] DIR_RIGHT = 2'd0;   // col + 1
    localparam logic [1:0] DIR_DOWN  = 2'd1;   // row + 1
    localparam logic [1:0] DIR_LEFT  = 2'd2;   // col - 1
    localparam logic [1:0] DIR_UP    = 2'd3;   // row - 1

    // Checker verdict error codes.
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_BOUND  = 2'd1;
    localparam logic [1:0] ERR_WALL   = 2'd2;
    localparam logic [1:0] ERR_NOEXIT = 2'd3;

    // Checker control states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_PATH = 3'd2,
        TRACK     = 3'd3,
        REPORT    = 3'd4
    } state_t;

endpackage : maze_pkg
`default_nettype wire

// File: rtl/maze_bitmap.sv
`default_nettype none
// ============================================================================
// Module      : maze_bitmap
// Description : CELLS x 1 maze occupancy storage (1 = open, 0 = wall).
//               Synchronous clear, one write port, one combinational read.
//               Out-of-range write indices are dropped; out-of-range reads
//               return 0 (wall).
// Ports       : clk, rst_n        - clock, async active-low reset (clears)
//               clr               - synchronous clear of every cell
//               wr_en/wr_idx/wr_data - single-bit write port
//               rd_idx/rd_data    - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module maze_bitmap
    import maze_pkg::*;
#(
    parameter int CELLS_N = CELLS,
    parameter int IDX_W   = $clog2(CELLS_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS_N - 1);

    logic [CELLS_N-1:0] cells;

    // Clear has priority so that a clear and a stray write on the same edge
    // still leaves an all-wall map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells <= '0;
        end else if (clr) begin
            cells <= '0;
        end else if (wr_en && (wr_idx <= LAST_IDX)) begin
            cells[wr_idx] <= wr_data;
        end
    end

    assign rd_data = (rd_idx <= LAST_IDX) ? cells[rd_idx] : 1'b0;

endmodule : maze_bitmap
`default_nettype wire

// File: rtl/maze_path_checker.sv
`default_nettype none
// ============================================================================
// Module      : maze_path_checker
// Description : Snoops the serial maze stream into a bitmap, then replays
//               the solver's direction stream from (0,0), checking every
//               move against the grid bounds and walls. Emits a one-cycle
//               registered verdict (pass, error code, move count).
// Ports       : clk, rst_n              - clock, async active-low reset
//               in_valid, in            - serial maze bits, cell 0 first
//               path_valid, path_dir    - solver direction beats
//               chk_valid               - one-cycle verdict strobe
//               chk_pass, chk_err       - verdict, qualified by chk_valid
//               chk_steps               - path beats consumed (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module maze_path_checker
    import maze_pkg::*;
#(
    parameter int DIM_P = DIM,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in,
    input  logic             path_valid,
    input  logic [1:0]       path_dir,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [1:0]       chk_err,
    output logic [CNT_W-1:0] chk_steps
);

    localparam int CELLS_N = DIM_P * DIM_P;
    localparam int IDX_W   = $clog2(CELLS_N);
    localparam int POS_W   = $clog2(DIM_P);

    localparam logic [POS_W-1:0] EDGE_POS = POS_W'(DIM_P - 1);
    localparam logic [IDX_W-1:0] LOAD_END = IDX_W'(CELLS_N);
    localparam logic [IDX_W-1:0] ROW_STEP = IDX_W'(DIM_P);

    state_t state, next_state;

    logic [IDX_W-1:0] load_idx;
    logic [POS_W-1:0] row, col;
    logic [CNT_W-1:0] count;
    logic [1:0]       err;

    logic             bm_clr;
    logic             bm_wr_en;
    logic [IDX_W-1:0] bm_wr_idx;
    logic             tgt_open;

    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] tgt_idx;
    logic [POS_W-1:0] tgt_row, tgt_col;
    logic             bound_hit;
    logic             at_exit;
    logic             beat;
    logic [1:0]       final_err;

    // ------------------------------------------------------------------
    // Maze storage
    // ------------------------------------------------------------------
    // The map is wiped on the REPORT -> IDLE edge so the next load starts
    // from all walls; cells a short stream never reaches stay walls.
    assign bm_clr    = (state == REPORT);
    assign bm_wr_en  = in_valid && ((state == IDLE) || (state == LOAD));
    assign bm_wr_idx = (state == IDLE) ? '0 : load_idx;

    maze_bitmap #(
        .CELLS_N (CELLS_N),
        .IDX_W   (IDX_W)
    ) u_bitmap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bm_clr),
        .wr_en   (bm_wr_en),
        .wr_idx  (bm_wr_idx),
        .wr_data (in),
        .rd_idx  (tgt_idx),
        .rd_data (tgt_open)
    );

    // ------------------------------------------------------------------
    // Move evaluation
    // ------------------------------------------------------------------
    assign cur_idx = IDX_W'(row) * ROW_STEP + IDX_W'(col);

    always_comb begin
        bound_hit = 1'b0;
        tgt_row   = row;
        tgt_col   = col;
        case (path_dir)
            DIR_RIGHT: if (col == EDGE_POS) bound_hit = 1'b1; else tgt_col = col + 1'b1;
            DIR_DOWN:  if (row == EDGE_POS) bound_hit = 1'b1; else tgt_row = row + 1'b1;
            DIR_LEFT:  if (col == '0)       bound_hit = 1'b1; else tgt_col = col - 1'b1;
            default:   if (row == '0)       bound_hit = 1'b1; else tgt_row = row - 1'b1;
        endcase
    end

    // Target index is only formed when the move stays on the grid, so the
    // subtraction can never underflow into a bogus in-range cell.
    always_comb begin
        tgt_idx = cur_idx;
        if (!bound_hit) begin
            case (path_dir)
                DIR_RIGHT: tgt_idx = cur_idx + 1'b1;
                DIR_DOWN:  tgt_idx = cur_idx + ROW_STEP;
                DIR_LEFT:  tgt_idx = cur_idx - 1'b1;
                default:   tgt_idx = cur_idx - ROW_STEP;
            endcase
        end
    end

    assign at_exit   = (row == EDGE_POS) && (col == EDGE_POS);
    assign beat      = path_valid && ((state == WAIT_PATH) || (state == TRACK));
    assign final_err = ((err == ERR_NONE) && !at_exit) ? ERR_NOEXIT : err;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (in_valid)    next_state = LOAD;
            LOAD:      if (!in_valid)   next_state = WAIT_PATH;
            WAIT_PATH: if (path_valid)  next_state = TRACK;
            TRACK:     if (!path_valid) next_state = REPORT;
            REPORT:                     next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered verdict
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx  <= '0;
            row       <= '0;
            col       <= '0;
            count     <= '0;
            err       <= ERR_NONE;
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            chk_err   <= ERR_NONE;
            chk_steps <= '0;
        end else begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            chk_err   <= ERR_NONE;
            chk_steps <= '0;

            case (state)
                IDLE, LOAD: begin
                    // Tracking context is held at the origin until the
                    // first path beat arrives.
                    row   <= '0;
                    col   <= '0;
                    count <= '0;
                    err   <= ERR_NONE;
                    if (state == IDLE) begin
                        load_idx <= IDX_W'(1);
                    end else if (in_valid && (load_idx != LOAD_END)) begin
                        // Stop at CELLS so an over-long stream cannot wrap.
                        load_idx <= load_idx + 1'b1;
                    end
                end
                REPORT: begin
                    chk_valid <= 1'b1;
                    chk_steps <= count;
                    chk_err   <= final_err;
                    chk_pass  <= (final_err == ERR_NONE);
                end
                default: begin
                    if (beat) begin
                        if (count != {CNT_W{1'b1}}) begin
                            count <= count + 1'b1;
                        end
                        // First error wins; afterwards the position freezes.
                        if (err == ERR_NONE) begin
                            if (bound_hit) begin
                                err <= ERR_BOUND;
                            end else if (!tgt_open) begin
                                err <= ERR_WALL;
                            end else begin
                                row <= tgt_row;
                                col <= tgt_col;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule : maze_path_checker
`default_nettype wire
